// File: rtl/entropy_source_select_pkg.sv
// Shared constants for the entropy source-selection stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Holds the channel index map, selector width and blanking counter width
// used by the interface, the mux and the top.
package entropy_source_select_pkg;

   localparam int SEL_W = 2;
   localparam int CNT_W = 4;

   localparam logic [SEL_W-1:0] CH_RING   = 2'd0;
   localparam logic [SEL_W-1:0] CH_ALT    = 2'd1;
   localparam logic [SEL_W-1:0] CH_REPEAT = 2'd2;
   localparam logic [SEL_W-1:0] CH_USER   = 2'd3;

endpackage

// File: rtl/entropy_source_select_if.sv
// Bundles the entropy channel inputs, selector and selected outputs.
// Latency: n/a (wires only).
// Backpressure: none; valid-only stream, no ready.
// Ports: ext_bit/ext_valid/sel (master -> slave); bit_out, valid_out,
//        src_changed, alt_bit (slave -> master).
interface entropy_source_select_if;
   import entropy_source_select_pkg::*;

   logic [3:0]       ext_bit;
   logic [3:0]       ext_valid;
   logic [SEL_W-1:0] sel;
   logic             bit_out;
   logic             valid_out;
   logic             src_changed;
   logic             alt_bit;

   modport master (
      output ext_bit, ext_valid, sel,
      input  bit_out, valid_out, src_changed, alt_bit
   );

   modport slave (
      input  ext_bit, ext_valid, sel,
      output bit_out, valid_out, src_changed, alt_bit
   );

endinterface

// File: rtl/entropy_source_select_mux4_sel.sv
// Generic 4:1 single-bit selector.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: d (4-bit candidate vector), s (2-bit index), y (selected bit).
module mux4_sel
   import entropy_source_select_pkg::*;
(
   input  logic [3:0]       d,
   input  logic [SEL_W-1:0] s,
   output logic             y
);

   always_comb begin
      y = d[s];
   end

endmodule

// File: rtl/entropy_source_select.sv
// TRNG front-end: alternating mock RNG on channel 1, 4:1 source mux,
// selector-change pulse and post-change validity blanking.
// Latency: zero cycles sel/ext_* -> outputs; one cycle when
//          ENTROPY_SELECT_REG_OUT_EN is defined (registered outputs).
// Backpressure: none; downstream must qualify bit_out with valid_out.
// Ports: clk, rst (synchronous, active-high), bus (entropy_source_select_if.slave).
module entropy_source_select
   import entropy_source_select_pkg::*;
#(
   parameter logic        ALT_INIT     = 1'b0,
   parameter int unsigned BLANK_CYCLES = 2
)
(
   input  logic                     clk,
   input  logic                     rst,
   entropy_source_select_if.slave   bus
);

   logic             alt_bit_q;
   logic             alt_valid_q;
   logic [SEL_W-1:0] sel_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       ch_bit;
   logic [3:0]       ch_valid;
   logic             mux_bit;
   logic             mux_valid;
   logic             chg;
   logic             valid_comb;

   // Alternating generator: deterministic stand-in source on the alt channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         alt_bit_q   <= ALT_INIT;
         alt_valid_q <= 1'b0;
      end else begin
         alt_bit_q   <= ~alt_bit_q;
         alt_valid_q <= 1'b1;
      end
   end

   // Channel 1 of the external vectors is replaced by the alternating source.
   always_comb begin
      ch_bit           = bus.ext_bit;
      ch_valid         = bus.ext_valid;
      ch_bit[CH_ALT]   = alt_bit_q;
      ch_valid[CH_ALT] = alt_valid_q;
   end

   mux4_sel u_mux_bit (
      .d (ch_bit),
      .s (bus.sel),
      .y (mux_bit)
   );

   mux4_sel u_mux_valid (
      .d (ch_valid),
      .s (bus.sel),
      .y (mux_valid)
   );

   // sel_q keeps tracking through reset, so a selector held across reset
   // release does not look like a change.
   always_ff @(posedge clk) begin
      sel_q <= bus.sel;
   end

   assign chg = (bus.sel != sel_q) & ~rst;

   // Blanking window: reloads on every change, so a change inside the
   // window restarts it; otherwise counts down and parks at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (chg) begin
         cnt_q <= CNT_W'(BLANK_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign valid_comb = mux_valid & ~chg & (cnt_q == '0);
   assign bus.alt_bit = alt_bit_q;

`ifdef ENTROPY_SELECT_REG_OUT_EN
   logic bit_out_q;
   logic valid_out_q;
   logic src_changed_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_out_q     <= ALT_INIT;
         valid_out_q   <= 1'b0;
         src_changed_q <= 1'b0;
      end else begin
         bit_out_q     <= mux_bit;
         valid_out_q   <= valid_comb;
         src_changed_q <= chg;
      end
   end

   assign bus.bit_out     = bit_out_q;
   assign bus.valid_out   = valid_out_q;
   assign bus.src_changed = src_changed_q;
`else
   assign bus.bit_out     = mux_bit;
   assign bus.valid_out   = valid_comb;
   assign bus.src_changed = chg;
`endif

endmodule

// File: tb/tb_entropy_source_select.sv
// Self-checking bench for entropy_source_select: directed vector table plus
// randomized traffic compared against a history-based reference model.
// Latency/backpressure: n/a (testbench).
module tb_entropy_source_select;
   import entropy_source_select_pkg::*;

   localparam logic ALT_INIT = 1'b0;
   localparam int   B        = 2;
   localparam int   H        = 1024;

   logic clk = 1'b0;
   logic rst;

   entropy_source_select_if bus();

   entropy_source_select #(
      .ALT_INIT     (ALT_INIT),
      .BLANK_CYCLES (B)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = -1;

   logic       h_rst [H];
   logic [1:0] h_sel [H];
   logic [3:0] h_eb  [H];
   logic [3:0] h_ev  [H];

   // ---------------- reference model (per-cycle history) ----------------
   function automatic logic m_pulse(int k);
      logic p;
      p = 1'b0;
      if (k >= 1) p = !h_rst[k] && (h_sel[k] != h_sel[k-1]);
      return p;
   endfunction

   // Blanked if a change happened within the last B cycles before c and no
   // reset cycle lies strictly between that change and c.
   function automatic logic m_blank(int c);
      logic bl;
      bl = 1'b0;
      for (int k = c - B; k < c; k++) begin
         if (k >= 1 && m_pulse(k)) begin
            logic cleared;
            cleared = 1'b0;
            for (int j = k + 1; j < c; j++) if (h_rst[j]) cleared = 1'b1;
            if (!cleared) bl = 1'b1;
         end
      end
      return bl;
   endfunction

   // Alternating bit = ALT_INIT flipped once per non-reset cycle since the last reset cycle.
   function automatic logic m_alt(int c);
      int n;
      n = 0;
      for (int j = c - 1; j >= 0 && !h_rst[j]; j--) n++;
      return ALT_INIT ^ n[0];
   endfunction

   function automatic logic m_altv(int c);
      return !h_rst[c-1];
   endfunction

   task automatic m_comb(input int c, output logic b, output logic v, output logic ch);
      logic [3:0] eb;
      logic [3:0] ev;
      eb = h_eb[c];
      ev = h_ev[c];
      if (h_sel[c] == CH_ALT) begin
         b = m_alt(c);
         v = m_altv(c);
      end else begin
         b = eb[h_sel[c]];
         v = ev[h_sel[c]];
      end
      ch = m_pulse(c);
      v  = v & !ch & !m_blank(c);
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [1:0] s, input logic [3:0] b, input logic [3:0] v);
      @(negedge clk);
      cyc++;
      rst           = r;
      bus.sel       = s;
      bus.ext_bit   = b;
      bus.ext_valid = v;
      h_rst[cyc] = r;
      h_sel[cyc] = s;
      h_eb[cyc]  = b;
      h_ev[cyc]  = v;
      #2;
   endtask

   task automatic model_check();
      logic b, v, ch;
      if (cyc >= 1) chk("model_alt_bit", bus.alt_bit, m_alt(cyc));
`ifdef ENTROPY_SELECT_REG_OUT_EN
      if (cyc >= 2) begin
         if (h_rst[cyc-1]) begin
            b = ALT_INIT; v = 1'b0; ch = 1'b0;
         end else begin
            m_comb(cyc - 1, b, v, ch);
         end
         chk("model_bit_out", bus.bit_out, b);
         chk("model_valid_out", bus.valid_out, v);
         chk("model_src_changed", bus.src_changed, ch);
      end
`else
      if (cyc >= 1) begin
         m_comb(cyc, b, v, ch);
         chk("model_bit_out", bus.bit_out, b);
         chk("model_valid_out", bus.valid_out, v);
         chk("model_src_changed", bus.src_changed, ch);
      end
`endif
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst;
      logic [1:0] sel;
      logic [3:0] eb;
      logic [3:0] ev;
      logic       chk;
      logic       e_bit;
      logic       e_valid;
      logic       e_chg;
      logic       e_alt;
   } vec_t;

   vec_t tbl [38];

   initial begin
      rst           = 1'b1;
      bus.sel       = 2'd1;
      bus.ext_bit   = 4'b0000;
      bus.ext_valid = 4'b0000;

      //           rst  sel   eb       ev      chk  bit  val  chg  alt
      // reset with alt channel selected, then alternation
      tbl[0]  = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      // move to channel 2, wait out blanking, then pass-through
      tbl[7]  = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 2'd2, 4'b0100, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 2'd2, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 2'd2, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      // settle on channel 0, then single step to 3
      tbl[13] = '{1'b0, 2'd0, 4'b0001, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[14] = '{1'b0, 2'd0, 4'b0001, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[15] = '{1'b0, 2'd0, 4'b0001, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b0, 2'd0, 4'b0001, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[17] = '{1'b0, 2'd3, 4'b1000, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 2'd3, 4'b1000, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[19] = '{1'b0, 2'd3, 4'b1000, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 2'd3, 4'b1000, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      // back to 0, then 0->1->2 on consecutive cycles
      tbl[21] = '{1'b0, 2'd0, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 2'd0, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[23] = '{1'b0, 2'd0, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[24] = '{1'b0, 2'd0, 4'b0001, 4'b0111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[25] = '{1'b0, 2'd1, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[26] = '{1'b0, 2'd2, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[27] = '{1'b0, 2'd2, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[28] = '{1'b0, 2'd2, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[29] = '{1'b0, 2'd2, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      // sel changed to 3 while in reset and held: no pulse on release
      tbl[30] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[31] = '{1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[32] = '{1'b0, 2'd3, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[33] = '{1'b0, 2'd3, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      // reset one cycle after a change clears the blanking window
      tbl[34] = '{1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[35] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[36] = '{1'b0, 2'd0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[37] = '{1'b0, 2'd0, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

      for (int i = 0; i < 38; i++) begin
         step(tbl[i].rst, tbl[i].sel, tbl[i].eb, tbl[i].ev);
`ifndef ENTROPY_SELECT_REG_OUT_EN
         if (tbl[i].chk) begin
            chk("tbl_bit_out", bus.bit_out, tbl[i].e_bit);
            chk("tbl_valid_out", bus.valid_out, tbl[i].e_valid);
            chk("tbl_src_changed", bus.src_changed, tbl[i].e_chg);
            chk("tbl_alt_bit", bus.alt_bit, tbl[i].e_alt);
         end
`endif
         model_check();
      end

      // Hand sequence: a change inside the blanking window restarts it.
      step(1'b0, 2'd3, 4'b1111, 4'b1111);
      model_check();
      chk("restart_first_pulse", bus.src_changed, 1'b1);
      step(1'b0, 2'd3, 4'b1111, 4'b1111);
      model_check();
      step(1'b0, 2'd2, 4'b1111, 4'b1111);
      model_check();
      chk("restart_second_pulse", bus.src_changed, 1'b1);
      for (int i = 0; i < B; i++) begin
         step(1'b0, 2'd2, 4'b1111, 4'b1111);
         model_check();
`ifndef ENTROPY_SELECT_REG_OUT_EN
         chk("restart_blanked", bus.valid_out, 1'b0);
`endif
      end
      step(1'b0, 2'd2, 4'b1111, 4'b1111);
      model_check();
`ifndef ENTROPY_SELECT_REG_OUT_EN
      chk("restart_window_end", bus.valid_out, 1'b1);
`endif

      // Randomized traffic against the reference model.
      begin
         logic [1:0] s;
         s = 2'd2;
         for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 2) == 0) s = 2'($urandom_range(0, 3));
            step(r, s, 4'($urandom), 4'($urandom));
            model_check();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/entropy_source_select.md
Name: entropy_source_select

Overview:
- Front-end source-selection stage of the TRNG datapath, sitting ahead of the Von Neumann unbiaser.
- Contains a deterministic alternating mock RNG on channel 1.
- Muxes four entropy channels (bit + valid) by a 2-bit selector.
- Detects selector changes, emits a one-cycle change pulse, and blanks output validity for a configurable number of cycles so downstream stages can resynchronise.

Parameters:
- ALT_INIT, 1'b0, value of the alternating bit while reset is asserted.
- BLANK_CYCLES, 2, cycles valid_out is forced low after the change-pulse cycle (0..15; 0 = blank only the pulse cycle).

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- ext_bit  input  4  external entropy bits, index = channel; ext_bit[1] ignored.
- ext_valid  input  4  external valid flags, index = channel; ext_valid[1] ignored.
- sel  input  2  channel selector, 0..3.
- bit_out  output  1  selected entropy bit.
- valid_out  output  1  selected valid, gated by blanking.
- src_changed  output  1  one-cycle pulse on selector change.
- alt_bit  output  1  alternating generator bit (debug tap).

Behaviour:
- Alternating generator:
  - alt_bit register: loads ALT_INIT while rst=1; otherwise toggles every clock.
  - alt_valid register: 0 while rst=1; 1 from the first edge with rst=0.
  - Channel 1 is {alt_bit, alt_valid}. Channels 0, 2 and 3 are {ext_bit[i], ext_valid[i]}.
- mux4:
  - Purely combinational 4:1 select of the bit vector and the valid vector by sel.
  - The same mux function is instantiated twice: once for bits, once for valids.
- Change detector:
  - sel_q register samples sel on every clock edge, including while rst=1. Consequence: no spurious pulse after reset release.
  - src_changed = (sel != sel_q) & ~rst, combinational.
  - A single sel step therefore yields exactly one high cycle.
  - A sel that changes on consecutive cycles yields a pulse on each cycle.
- Blanking counter:
  - 4-bit counter, 0 on reset.
  - On a cycle with src_changed=1, loads BLANK_CYCLES.
  - Otherwise decrements when nonzero, saturating at 0.
- Outputs:
  - valid_out = mux_valid & ~src_changed & (cnt == 0).
  - bit_out = mux_bit, never gated. Downstream logic must qualify it with valid_out.
- Reset values:
  - alt_bit = ALT_INIT.
  - valid_out = 0 (alt channel invalid; counter 0, so external channels pass through combinationally).
  - src_changed = 0.
- Reset mid-blanking: the counter clears immediately on the next edge.
- A sel change during blanking reloads the counter (restarts the window).
- Latency: zero cycles from ext_* / sel to bit_out and valid_out (except with the optional feature below).

Optional Feature:
- Macro: ENTROPY_SELECT_REG_OUT_EN.
- When defined:
  - bit_out, valid_out and src_changed are registered, adding exactly one cycle of latency.
  - The registers reset to 0, with bit_out resetting to ALT_INIT.
- When undefined: outputs are combinational as described above.

Decomposition:
- Shared package holds:
  - channel index constants: CH_RING=0, CH_ALT=1, CH_REPEAT=2, CH_USER=3;
  - the selector width constant SEL_W=2;
  - the blanking counter width constant.
- One natural sub-module: mux4_sel (generic 4:1, 4-bit input vector, 2-bit select, 1-bit out), instantiated twice.
- The alternating generator and the change detector stay inline.

Test Plan:
- Reset and alternation:
  - Stimulus: rst=1 for 3 cycles, ALT_INIT=0, sel=1.
  - Required: alt_bit=0 and valid_out=0 during reset.
  - After release: alt_bit sequence 1,0,1,0…; valid_out=1 from the first post-reset cycle onward, except the blank window is not entered.
- Mux pass-through:
  - Stimulus: sel=2, ext_bit=4'b0100, ext_valid=4'b0100.
  - Required: bit_out=1, valid_out=1 in the same cycle.
  - Then sel held, ext_valid[2]=0 → valid_out=0.
- Change pulse and blanking:
  - Stimulus: stable sel=0 with ext_valid[0]=1; step sel to 3 (ext_valid[3]=1) at cycle N.
  - Required: src_changed=1 only at cycle N; valid_out=0 at cycles N, N+1, N+2 and 1 at N+3 (BLANK_CYCLES=2).
- Back-to-back changes:
  - Stimulus: sel 0→1→2 on consecutive cycles.
  - Required: src_changed high on both cycles; valid_out low until 2 cycles after the last change.
- No pulse out of reset: drive sel=3 during reset and hold it → src_changed stays 0 after release.
- Reset mid-blank: assert rst one cycle after a change → cnt=0 and src_changed=0 after that edge; valid_out follows ext_valid once rst drops.
